// File: rtl/fft_stage_sequencer.sv
// Stage sequencer for an in-place radix-2 DIT FFT over a ping-pong bank pair.
// Issues butterfly read/twiddle addresses and replays them as write addresses after the pipeline delay.
module fft_stage_sequencer #(
  parameter int LOG2N   = 5,
  parameter int RAM_LAT = 1,
  parameter int BF_LAT  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             select,
  output logic [LOG2N-1:0] addr_1,
  output logic [LOG2N-1:0] addr_2,
  output logic [LOG2N-1:0] addw_1,
  output logic [LOG2N-1:0] addw_2,
  output logic             write_enable,
  output logic [LOG2N-2:0] tw_addr,
  output logic             bf_valid,
  output logic [2:0]       stage,
  output logic [2:0]       stateDbg
);
  localparam int D  = RAM_LAT + BF_LAT;
  localparam int DW = $clog2(D + 1);
  localparam logic [LOG2N-2:0] K_LAST     = '1;  // N/2-1 is all ones
  localparam logic [2:0]       STAGE_LAST = 3'(LOG2N - 1);
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(D - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, SWAP, DONE} state_t;

  state_t state, nextState;
  logic [LOG2N-2:0] kCnt;
  logic [2:0]       stageCnt;
  logic [DW-1:0]    drainCnt;
  logic             selectR;
  logic             issuing;

  logic [LOG2N-1:0] kExt, span, pos, grp, rdA1, rdA2, twFull;

  logic [LOG2N-1:0] dlA1 [D];
  logic [LOG2N-1:0] dlA2 [D];
  logic             dlV  [D];

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = ISSUE;
      ISSUE:   if (kCnt == K_LAST) nextState = DRAIN;
      DRAIN:   if (drainCnt == DRAIN_LAST) nextState = SWAP;
      SWAP:    nextState = (stageCnt == STAGE_LAST) ? DONE : ISSUE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Counters only move in their own state, so start outside IDLE has no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kCnt     <= '0;
      stageCnt <= '0;
      drainCnt <= '0;
      selectR  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          kCnt     <= '0;
          stageCnt <= '0;
          selectR  <= 1'b0;
        end
        ISSUE: begin
          drainCnt <= '0;
          if (kCnt != K_LAST) kCnt <= kCnt + 1'b1;
        end
        DRAIN: if (drainCnt != DRAIN_LAST) drainCnt <= drainCnt + 1'b1;
        SWAP: begin
          selectR  <= ~selectR;
          kCnt     <= '0;
          stageCnt <= (stageCnt == STAGE_LAST) ? 3'd0 : stageCnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // In-place butterfly indexing: legs are span apart inside groups of 2*span.
  always_comb begin
    kExt   = {1'b0, kCnt};
    span   = {{(LOG2N-1){1'b0}}, 1'b1} << stageCnt;
    pos    = kExt & (span - 1'b1);
    grp    = kExt >> stageCnt;
    rdA1   = ((grp << stageCnt) << 1) | pos;
    rdA2   = rdA1 + span;
    twFull = pos << (STAGE_LAST - stageCnt);
  end

  assign issuing = (state == ISSUE);
  assign addr_1  = issuing ? rdA1 : '0;
  assign addr_2  = issuing ? rdA2 : '0;
  assign tw_addr = issuing ? twFull[LOG2N-2:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) begin
        dlA1[i] <= '0;
        dlA2[i] <= '0;
        dlV[i]  <= 1'b0;
      end
    end else begin
      dlA1[0] <= addr_1;
      dlA2[0] <= addr_2;
      dlV[0]  <= issuing;
      for (int i = 1; i < D; i++) begin
        dlA1[i] <= dlA1[i-1];
        dlA2[i] <= dlA2[i-1];
        dlV[i]  <= dlV[i-1];
      end
    end
  end

  assign addw_1       = dlA1[D-1];
  assign addw_2       = dlA2[D-1];
  assign write_enable = dlV[D-1];
  assign bf_valid     = dlV[RAM_LAT-1];
  assign busy         = (state == ISSUE) || (state == DRAIN) || (state == SWAP);
  assign done         = (state == DONE);
  assign select       = selectR;
  assign stage        = stageCnt;
  assign stateDbg     = state;
endmodule
